synch_link_arbiter: RTL and testbench

//   Transmit-side scheduler for the synchronous serial link drained by the team's synch receiver.

---
 rtl/synch_link_arbiter.sv | 169 ++++++++++++++++
 tb/tb_synch_link_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synch_link_arbiter.sv
// ============================================================================
// synch_link_arbiter : round-robin scheduler and 12-cycle frame serialiser
// Revision 1.0
// ============================================================================
`default_nettype none

module synch_link_arbiter #(
   parameter int NREQ       = 4,
   parameter int PARITY_ODD = 0,
   parameter int GAP_CYCLES = 1
) (
   input  logic              data_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   grant,
   output logic [2:0]        grant_id,
   output logic              busy,
   output logic              frame_done,
   output logic              data_point,
   output logic              Enable
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START1 = 3'd1,
      S_START2 = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5,
      S_GAP    = 3'd6
   } state_t;

   localparam logic       PAR_INV  = (PARITY_ODD != 0);
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   state_t            state_q;
   logic [2:0]        ptr_q;
   logic [NREQ-1:0]   grant_q;
   logic [2:0]        grant_id_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              line_q;
   logic              en_q;
   logic [7:0]        shreg_q;
   logic              par_q;
   logic [3:0]        cnt_q;

   logic              found_d;
   logic [2:0]        win_d;
   logic [NREQ-1:0]   grant_d;
   logic [7:0]        byte_d;
   int                idx;

   // First set request scanning upward from the slot after the last winner.
   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      grant_d = '0;
      byte_d  = '0;
      idx     = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(ptr_q) + i) % NREQ;
         if (!found_d && req[idx]) begin
            found_d      = 1'b1;
            win_d        = 3'(idx);
            grant_d[idx] = 1'b1;
            byte_d       = req_data[8*idx +: 8];
         end
      end
   end

   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= 3'(NREQ - 1);
         grant_q      <= '0;
         grant_id_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         line_q       <= 1'b1;
         en_q         <= 1'b0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         en_q         <= enable;
         grant_q      <= '0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               line_q <= 1'b1;
               busy_q <= 1'b0;
               if (enable && found_d) begin
                  ptr_q      <= win_d;
                  grant_id_q <= win_d;
                  grant_q    <= grant_d;
                  shreg_q    <= byte_d;
                  par_q      <= (^byte_d) ^ PAR_INV;
                  line_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_START1;
               end
            end
            // Second start cycle covers the receiver's non-sampling START state.
            S_START1: begin
               line_q  <= 1'b0;
               state_q <= S_START2;
            end
            S_START2: begin
               line_q  <= shreg_q[0];
               shreg_q <= {1'b0, shreg_q[7:1]};
               cnt_q   <= '0;
               state_q <= S_DATA;
            end
            S_DATA: begin
               if (cnt_q == 4'd7) begin
                  line_q  <= par_q;
                  state_q <= S_PARITY;
               end else begin
                  line_q  <= shreg_q[0];
                  shreg_q <= {1'b0, shreg_q[7:1]};
                  cnt_q   <= cnt_q + 4'd1;
               end
            end
            S_PARITY: begin
               line_q       <= 1'b1;
               frame_done_q <= 1'b1;
               state_q      <= S_STOP;
            end
            S_STOP: begin
               line_q <= 1'b1;
               cnt_q  <= '0;
               if (GAP_CYCLES == 0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               line_q <= 1'b1;
               if (cnt_q == GAP_LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               line_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign grant_id   = grant_id_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign data_point = line_q;
   assign Enable     = en_q;

endmodule

`default_nettype wire

// File: tb/tb_synch_link_arbiter.sv
// ============================================================================
// tb_synch_link_arbiter : directed bench for synch_link_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_synch_link_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [3:0]  req;
   logic [31:0] req_data;

   logic [3:0]  grant,      grant_o;
   logic [2:0]  grant_id,   grant_id_o;
   logic        busy,       busy_o;
   logic        frame_done, frame_done_o;
   logic        data_point, data_point_o;
   logic        en_out,     en_out_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   synch_link_arbiter #(.NREQ(4), .PARITY_ODD(0), .GAP_CYCLES(1)) dut (
      .data_clk(clk), .reset(rst), .enable(enable), .req(req), .req_data(req_data),
      .grant(grant), .grant_id(grant_id), .busy(busy), .frame_done(frame_done),
      .data_point(data_point), .Enable(en_out)
   );

   synch_link_arbiter #(.NREQ(4), .PARITY_ODD(1), .GAP_CYCLES(1)) dut_odd (
      .data_clk(clk), .reset(rst), .enable(enable), .req(req), .req_data(req_data),
      .grant(grant_o), .grant_id(grant_id_o), .busy(busy_o), .frame_done(frame_done_o),
      .data_point(data_point_o), .Enable(en_out_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy || busy_o) && k < 40) begin
         tick();
         k++;
      end
      n_checks++;
      if (busy || busy_o) $display("FAIL wait_idle: busy=%b still high after 40 cycles, want 0", busy);
      else n_pass++;
   endtask

   // Next edge must be the IDLE arbitration edge E0; captures line values after E0..E11.
   task automatic run_frame(output logic [11:0] line, output logic [11:0] line_odd,
                            output logic [11:0] fd, output logic [3:0] g0);
      line = '0; line_odd = '0; fd = '0; g0 = '0;
      for (int k = 0; k < 12; k++) begin
         tick();
         line[k]     = data_point;
         line_odd[k] = data_point_o;
         fd[k]       = frame_done;
         if (k == 0) begin
            g0  = grant;
            req = '0;
         end
      end
   endtask

   task automatic test_reset();
      enable = 1'b1;
      req = '0;
      req_data = '0;
      rst = 1'b1;
      #2;
      n_checks++;
      if ({data_point, busy, grant, grant_id, frame_done, en_out} !== 11'b1_0_0000_000_0_0)
         $display("FAIL reset_values: got %b want %b",
                  {data_point, busy, grant, grant_id, frame_done, en_out}, 11'b1_0_0000_000_0_0);
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if ({data_point, busy, grant} !== 6'b1_0_0000)
            $display("FAIL idle_no_req cycle %0d: got line/busy/grant=%b want 100000", c, {data_point, busy, grant});
         else n_pass++;
      end
      n_checks++;
      if (en_out !== 1'b1) $display("FAIL enable_follow: got %b want 1", en_out);
      else n_pass++;
   endtask

   task automatic test_single_frame();
      logic [11:0] line, lo, fd;
      logic [3:0]  g0;
      logic [7:0]  numb;
      logic        parity_bit;
      do_reset();
      enable   = 1'b1;
      req_data = 32'h0000_00A5;
      req      = 4'b0001;
      run_frame(line, lo, fd, g0);
      n_checks++;
      if (g0 !== 4'b0001) $display("FAIL single_grant: got %b want 0001", g0);
      else n_pass++;
      n_checks++;
      if (line !== 12'hA94) $display("FAIL single_line: got %h want a94", line);
      else n_pass++;
      n_checks++;
      if (fd !== 12'h800) $display("FAIL single_frame_done: got %h want 800", fd);
      else n_pass++;
      numb       = line[9:2];
      parity_bit = line[10];
      n_checks++;
      if (numb !== 8'hA5) $display("FAIL rx_numb: got %h want a5", numb);
      else n_pass++;
      n_checks++;
      if (parity_bit !== 1'b0) $display("FAIL rx_parity: got %b want 0", parity_bit);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1 || grant_id !== 3'd0) $display("FAIL single_busy_id: got busy=%b id=%0d want 1/0", busy, grant_id);
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      int         n, cyc, last;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      enable   = 1'b1;
      req_data = 32'h4433_2211;
      req      = 4'b1111;
      n = 0; cyc = 0; last = 0;
      while (n < 5 && cyc < 100) begin
         tick();
         cyc++;
         if (grant !== 4'b0000) begin
            n_checks++;
            if (grant !== exp_g[n]) $display("FAIL rr_grant %0d: got %b want %b", n, grant, exp_g[n]);
            else n_pass++;
            n_checks++;
            if (grant_id !== 3'(n % 4)) $display("FAIL rr_grant_id %0d: got %0d want %0d", n, grant_id, n % 4);
            else n_pass++;
            if (n > 0) begin
               n_checks++;
               if (cyc - last !== 14) $display("FAIL rr_spacing %0d: got %0d want 14", n, cyc - last);
               else n_pass++;
            end
            last = cyc;
            n++;
         end
      end
      n_checks++;
      if (n !== 5) $display("FAIL rr_count: got %0d grants want 5", n);
      else n_pass++;
      req = '0;
      wait_idle();
   endtask

   task automatic test_parity_odd();
      logic [11:0] line, lo, fd;
      logic [3:0]  g0;
      do_reset();
      enable   = 1'b1;
      req_data = 32'h0000_0000;
      req      = 4'b0001;
      run_frame(line, lo, fd, g0);
      n_checks++;
      if (lo[10] !== 1'b1 || line[10] !== 1'b0)
         $display("FAIL parity_00: got odd=%b even=%b want 1/0", lo[10], line[10]);
      else n_pass++;
      wait_idle();
      req_data = 32'h0000_00FF;
      req      = 4'b0001;
      run_frame(line, lo, fd, g0);
      n_checks++;
      if (lo[10] !== 1'b1 || line[10] !== 1'b0)
         $display("FAIL parity_ff: got odd=%b even=%b want 1/0", lo[10], line[10]);
      else n_pass++;
      n_checks++;
      if (line[9:2] !== 8'hFF) $display("FAIL data_ff: got %h want ff", line[9:2]);
      else n_pass++;
      wait_idle();
   endtask

   task automatic test_enable_drop();
      logic [11:0] line;
      do_reset();
      enable   = 1'b1;
      req_data = 32'h0000_3C00;
      req      = 4'b0010;
      line     = '0;
      for (int k = 0; k < 12; k++) begin
         tick();
         line[k] = data_point;
         if (k == 0) begin
            n_checks++;
            if (grant !== 4'b0010) $display("FAIL endrop_grant: got %b want 0010", grant);
            else n_pass++;
         end
         if (k == 4) enable = 1'b0;
         if (k == 5) begin
            n_checks++;
            if (en_out !== 1'b0) $display("FAIL endrop_Enable: got %b want 0", en_out);
            else n_pass++;
         end
      end
      n_checks++;
      if (line !== 12'h8F0) $display("FAIL endrop_line: got %h want 8f0", line);
      else n_pass++;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if (grant !== 4'b0000) $display("FAIL endrop_no_grant cycle %0d: got %b want 0000", c, grant);
         else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL endrop_busy: got %b want 0", busy);
      else n_pass++;
      enable = 1'b1;
      tick();
      n_checks++;
      if (grant !== 4'b0010) $display("FAIL endrop_regrant: got %b want 0010", grant);
      else n_pass++;
      req = '0;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      enable   = 1'b1;
      req_data = 32'h00A5_0000;
      req      = 4'b0100;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k == 0) begin
            n_checks++;
            if (grant !== 4'b0100) $display("FAIL mid_grant: got %b want 0100", grant);
            else n_pass++;
         end
      end
      n_checks++;
      if (data_point !== 1'b0 || busy !== 1'b1)
         $display("FAIL mid_before_reset: got line=%b busy=%b want 0/1", data_point, busy);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({data_point, busy, grant} !== 6'b1_0_0000)
         $display("FAIL mid_async_reset: got line/busy/grant=%b want 100000", {data_point, busy, grant});
      else n_pass++;
      #1;
      rst = 1'b0;
      tick();
      n_checks++;
      if (grant !== 4'b0100 || data_point !== 1'b0)
         $display("FAIL mid_restart_E0: got grant=%b line=%b want 0100/0", grant, data_point);
      else n_pass++;
      req = '0;
      tick();
      n_checks++;
      if (data_point !== 1'b0 || grant !== 4'b0000)
         $display("FAIL mid_restart_E1: got line=%b grant=%b want 0/0000", data_point, grant);
      else n_pass++;
      tick();
      n_checks++;
      if (data_point !== 1'b1) $display("FAIL mid_restart_bit0: got %b want 1", data_point);
      else n_pass++;
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      req = '0;
      req_data = '0;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_parity_odd();
      test_enable_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
